bram_frame_ctrl: RTL
====================

Name: bram_frame_ctrl

Overview:
- Sequences the ThresholdCutter sample BRAM (2**BLOCK_NUM_INDEX blocks x 2**BLOCK_DEPTH_INDEX words) as a circular queue of fixed-size frames.
- Write side: fills frames from an incoming sample stream.
- Read side: streams complete frames, oldest first, to the downstream cutter logic.
- Sole master of both BRAM ports. Prevents overwrite of unread frames via back-pressure.

Parameters:
- BLOCK_NUM_INDEX, 6, log2 of frame (block) count.
- BLOCK_DEPTH_INDEX, 9, log2 of words per frame.
- BLOCK_WIDTH, 32, sample/word width in bits.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- clr  in  1  synchronous soft clear: empties queue, aborts stream.
- in_valid  in  1  input sample valid.
- in_data  in  BLOCK_WIDTH  input sample.
- in_ready  out  1  controller accepts sample.
- rd_en  in  1  permit starting a new frame readout.
- out_valid  out  1  output word valid.
- out_data  out  BLOCK_WIDTH  output word.
- out_last  out  1  final word of frame.
- out_ready  in  1  downstream accepts word.
- full_cnt  out  BLOCK_NUM_INDEX+1  number of complete, unread frames.
- bram_wen  out  1  BRAM write enable.
- bram_wdata  out  BLOCK_WIDTH  BRAM write data.
- bram_waddr  out  BLOCK_NUM_INDEX+BLOCK_DEPTH_INDEX  BRAM write address.
- bram_raddr  out  BLOCK_NUM_INDEX+BLOCK_DEPTH_INDEX  BRAM read address.
- bram_rdata  in  BLOCK_WIDTH  BRAM read data (combinational read).

Behaviour:
- Reset (rst_n=0, async): wr_blk, wr_off, rd_blk, rd_off, full_cnt = 0; state IDLE. Outputs: in_ready=0 during reset, out_valid=0, out_last=0, bram_wen=0, bram_waddr=0, bram_raddr=0.
- Write path:
  - in_ready = !clr && (full_cnt != 2**BLOCK_NUM_INDEX).
  - bram_wen = in_valid & in_ready (combinational). bram_wdata = in_data. bram_waddr = {wr_blk, wr_off}.
  - On write: wr_off increments. When wr_off wraps to 0, wr_blk increments (mod 2**BLOCK_NUM_INDEX) and the frame counts as complete.
  - Writer never targets an unread complete frame: with full_cnt below max, wr_blk differs from every queued block.
- Read FSM, states IDLE and STREAM:
  - IDLE -> STREAM when rd_en && full_cnt != 0. rd_off = 0 on entry.
  - STREAM: out_valid=1, bram_raddr = {rd_blk, rd_off} from registers, out_data = bram_rdata (same cycle, no extra latency). out_last = (rd_off == all ones).
  - Handshake out_valid & out_ready: rd_off increments.
  - Handshake with out_last: rd_blk increments, frame retired, return to IDLE. At least one IDLE cycle between frames.
  - In IDLE: bram_raddr holds {rd_blk, 0}.
- full_cnt:
  - +1 on frame completion, -1 on frame retirement.
  - Both in the same cycle: unchanged.
  - Never exceeds 2**BLOCK_NUM_INDEX, never underflows.
- Back-pressure: out_ready low holds out_data/out_last stable (address unchanged). in_valid low stalls writing with no state change.
- clr (sync, priority over all): pointers and full_cnt to 0, state IDLE. Any in-progress frame on either side is discarded. No write and no output handshake in the clr cycle.
- Reset or clr mid-stream: out_valid drops next cycle (async for rst_n). The partial frame is lost, with no out_last.
- Wrap-around: wr_blk and rd_blk wrap naturally at 2**BLOCK_NUM_INDEX.
- Frame word order equals input order.

Decomposition:
- Shared package: BLOCK_NUM_INDEX/BLOCK_DEPTH_INDEX/BLOCK_WIDTH defaults, derived address width, FSM state encoding (IDLE=0, STREAM=1).
- No sub-module required. The optional counter helper is bram_frame_ptr (block/offset counter with wrap and tick-out), instantiated for the write and read sides.
- Bench instantiates the existing simulated BRAM model as the memory.

Test Plan (bench params BLOCK_NUM_INDEX=2, BLOCK_DEPTH_INDEX=3: 4 frames x 8 words):
- Write 8 words 0x10..0x17, rd_en=0 -> full_cnt=1 after the 8th write; bram_waddr ran 0..7.
- rd_en=1, out_ready=1 -> out_data 0x10..0x17 on 8 consecutive cycles, out_last on 0x17, full_cnt=0, FSM returns IDLE.
- Write 32 words with rd_en=0 -> full_cnt=4, in_ready=0, 33rd word not written (bram_wen=0).
- From full, retire one frame while in_valid=1 -> in_ready rises the cycle after retirement. New words go to block 0 addresses 0..7 (wrap).
- Last-word write and last-word read in the same cycle with full_cnt=2 -> full_cnt stays 2.
- Mid-stream (after word 3), out_ready toggled 0/1 -> data stable while stalled. Then clr=1 -> next cycle out_valid=0, full_cnt=0, bram_raddr=0. Repeat with rst_n pulse mid-cycle -> immediate async clear.

Source files
------------

// File: rtl/bram_frame_ctrl_pkg.sv
// Shared defaults, address-width helper and read-FSM encoding for the
// ThresholdCutter sample-BRAM frame controller.
package bram_frame_ctrl_pkg;

  localparam int BFC_BLOCK_NUM_INDEX   = 6;
  localparam int BFC_BLOCK_DEPTH_INDEX = 9;
  localparam int BFC_BLOCK_WIDTH       = 32;
  localparam int BFC_ADDR_W            = BFC_BLOCK_NUM_INDEX + BFC_BLOCK_DEPTH_INDEX;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_e;

  function automatic int addr_width(input int num_idx, input int depth_idx);
    return num_idx + depth_idx;
  endfunction

endpackage

// File: rtl/bram_frame_ptr.sv
// Block/offset pointer: offset counts words, block advances when the offset
// wraps; wrap_o flags the increment that completes a frame.
module bram_frame_ptr
  import bram_frame_ctrl_pkg::*;
#(
  parameter int BLK_W = BFC_BLOCK_NUM_INDEX,
  parameter int OFF_W = BFC_BLOCK_DEPTH_INDEX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [BLK_W-1:0] blk_o,
  output logic [OFF_W-1:0] off_o,
  output logic             wrap_o
);

  logic [BLK_W-1:0] blk_q, blk_d;
  logic [OFF_W-1:0] off_q, off_d;

  assign wrap_o = inc_i && !clr_i && (off_q == '1);
  assign blk_o  = blk_q;
  assign off_o  = off_q;

  always_comb begin
    blk_d = blk_q;
    off_d = off_q;
    if (clr_i) begin
      blk_d = '0;
      off_d = '0;
    end else if (inc_i) begin
      off_d = off_q + 1'b1;
      if (off_q == '1) blk_d = blk_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_q <= '0;
      off_q <= '0;
    end else begin
      blk_q <= blk_d;
      off_q <= off_d;
    end
  end

endmodule

// File: rtl/bram_frame_ctrl.sv
// Circular frame queue over the sample BRAM: write side fills frames, read FSM
// streams complete frames oldest-first.  state | meaning: IDLE | waiting for rd_en
// and a complete frame; STREAM | presenting words of frame rd_blk.
module bram_frame_ctrl
  import bram_frame_ctrl_pkg::*;
#(
  parameter int BLOCK_NUM_INDEX   = BFC_BLOCK_NUM_INDEX,
  parameter int BLOCK_DEPTH_INDEX = BFC_BLOCK_DEPTH_INDEX,
  parameter int BLOCK_WIDTH       = BFC_BLOCK_WIDTH,
  parameter int AW                = addr_width(BLOCK_NUM_INDEX, BLOCK_DEPTH_INDEX)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   in_valid,
  input  logic [BLOCK_WIDTH-1:0] in_data,
  output logic                   in_ready,
  input  logic                   rd_en,
  output logic                   out_valid,
  output logic [BLOCK_WIDTH-1:0] out_data,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic [BLOCK_NUM_INDEX:0] full_cnt,
  output logic                   bram_wen,
  output logic [BLOCK_WIDTH-1:0] bram_wdata,
  output logic [AW-1:0]          bram_waddr,
  output logic [AW-1:0]          bram_raddr,
  input  logic [BLOCK_WIDTH-1:0] bram_rdata
);

  localparam logic [BLOCK_NUM_INDEX:0] MAX_FRAMES = {1'b1, {BLOCK_NUM_INDEX{1'b0}}};

  rd_state_e                    state_q;
  logic                         out_valid_q;
  logic [BLOCK_NUM_INDEX:0]     full_cnt_q, full_cnt_d;
  logic [BLOCK_NUM_INDEX-1:0]   wr_blk, rd_blk;
  logic [BLOCK_DEPTH_INDEX-1:0] wr_off, rd_off;
  logic                         wr_fire, rd_fire, wr_done, rd_done;

  // rst_n gates ready so nothing is accepted while the queue is held in reset.
  assign in_ready   = rst_n && !clr && (full_cnt_q != MAX_FRAMES);
  assign wr_fire    = in_valid && in_ready;
  assign bram_wen   = wr_fire;
  assign bram_wdata = in_data;
  assign bram_waddr = {wr_blk, wr_off};

  assign rd_fire    = out_valid_q && out_ready && !clr;
  assign out_valid  = out_valid_q;
  assign out_data   = bram_rdata;
  assign out_last   = out_valid_q && (rd_off == '1);
  assign bram_raddr = {rd_blk, rd_off};
  assign full_cnt   = full_cnt_q;

  bram_frame_ptr #(.BLK_W(BLOCK_NUM_INDEX), .OFF_W(BLOCK_DEPTH_INDEX)) u_wr_ptr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (clr),
    .inc_i  (wr_fire),
    .blk_o  (wr_blk),
    .off_o  (wr_off),
    .wrap_o (wr_done)
  );

  // Read offset is back at zero after every retirement, so IDLE shows {rd_blk, 0}.
  bram_frame_ptr #(.BLK_W(BLOCK_NUM_INDEX), .OFF_W(BLOCK_DEPTH_INDEX)) u_rd_ptr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (clr),
    .inc_i  (rd_fire),
    .blk_o  (rd_blk),
    .off_o  (rd_off),
    .wrap_o (rd_done)
  );

  always_comb begin
    full_cnt_d = full_cnt_q;
    if (clr) begin
      full_cnt_d = '0;
    end else if (wr_done && !rd_done) begin
      full_cnt_d = full_cnt_q + 1'b1;
    end else if (rd_done && !wr_done) begin
      full_cnt_d = full_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      full_cnt_q  <= '0;
    end else begin
      full_cnt_q <= full_cnt_d;
      if (clr) begin
        state_q     <= IDLE;
        out_valid_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (rd_en && (full_cnt_q != '0)) begin
              state_q     <= STREAM;
              out_valid_q <= 1'b1;
            end
          end
          STREAM: begin
            if (rd_done) begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
            end
          end
          default: begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
